// File: rtl/reg_file_mp_pkg.sv
// Shared types for the multi-port register file and its background clear engine.
package reg_file_mp_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/reg_file_mp_clr_fsm.sv
// Background clear engine: walks every entry once, emitting one clear write per cycle.
module reg_file_clr_fsm
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        clr_we   = 1'b0;
        clr_addr = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                clr_busy = 1'b1;
                clr_we   = 1'b1;
                // Last entry: leave before idx can wrap; clr_req is ignored here.
                if (idx_q == '1) begin
                    clr_done = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with masked write, optional bypass/registered read
// and a background clear engine that re-initialises storage without reset.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           ADDR_WIDTH = 4,
    parameter int unsigned           NUM_RD     = 2,
    parameter int unsigned           RD_REG     = 0,
    parameter int unsigned           BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic [DATA_WIDTH-1:0]        w_data,
    input  logic [DATA_WIDTH-1:0]        w_mask,
    output logic                         wr_drop,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         clr_done
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_acc;
    logic [DATA_WIDTH-1:0] wr_merged;

    reg_file_clr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wr_acc    = wr_en & ~clr_busy;
    assign wr_drop   = wr_en & clr_busy;
    assign wr_merged = (mem_q[w_addr] & ~w_mask) | (w_data & w_mask);

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_acc) begin
            mem_d[w_addr] = wr_merged;
        end
        if (clr_we) begin
            mem_d[clr_addr] = RESET_VAL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd_val;

        assign ra = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Only host writes are forwarded; clear writes become visible after the edge.
        always_comb begin
            rd_val = mem_q[ra];
            if ((BYPASS != 0) && wr_acc && (ra == w_addr)) begin
                rd_val = wr_merged;
            end
        end

        if (RD_REG != 0) begin : g_reg
            logic [DATA_WIDTH-1:0] rd_q, rd_d;

            assign rd_d = rd_val;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_q <= RESET_VAL;
                end else begin
                    rd_q <= rd_d;
                end
            end

            assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_q;
        end else begin : g_comb
            assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_val;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: three configurations (bypass comb, no-bypass comb, registered read) share stimulus.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  w_addr = '0;
    logic [7:0]  w_data = '0;
    logic [7:0]  w_mask = '0;
    logic [7:0]  r_addr = '0;
    logic        clr_req = 1'b0;

    logic [15:0] rd_m, rd_nb, rd_rr;
    logic        drop_m, drop_nb, drop_rr;
    logic        busy_m, busy_nb, busy_rr;
    logic        done_m, done_nb, done_rr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_RD(2), .RD_REG(0), .BYPASS(1), .RESET_VAL(8'h00)) u_main (
        .clk(clk), .reset(reset), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .wr_drop(drop_m), .r_addr(r_addr), .r_data(rd_m), .clr_req(clr_req), .clr_busy(busy_m), .clr_done(done_m));

    reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_RD(2), .RD_REG(0), .BYPASS(0), .RESET_VAL(8'h00)) u_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .wr_drop(drop_nb), .r_addr(r_addr), .r_data(rd_nb), .clr_req(clr_req), .clr_busy(busy_nb), .clr_done(done_nb));

    reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .NUM_RD(2), .RD_REG(1), .BYPASS(1), .RESET_VAL(8'h00)) u_rr (
        .clk(clk), .reset(reset), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
        .wr_drop(drop_rr), .r_addr(r_addr), .r_data(rd_rr), .clr_req(clr_req), .clr_busy(busy_rr), .clr_done(done_rr));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
        wr_en  = 1'b1;
        w_addr = a;
        w_data = d;
        w_mask = m;
        step();
        wr_en  = 1'b0;
    endtask

    task automatic fill_ff();
        for (int a = 0; a < 16; a++) begin
            do_write(4'(a), 8'hFF, 8'hFF);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (rd_rr !== 16'h0000) begin errors++; $display("FAIL reset_rr_rdata actual=%h required=0000", rd_rr); end
        checks++;
        if ({busy_m, busy_nb, busy_rr, done_m, done_nb, done_rr, drop_m, drop_nb, drop_rr} !== 9'b0) begin
            errors++;
            $display("FAIL reset_status actual=%b required=000000000",
                     {busy_m, busy_nb, busy_rr, done_m, done_nb, done_rr, drop_m, drop_nb, drop_rr});
        end
        for (int a = 0; a < 16; a++) begin
            r_addr = {4'(15 - a), 4'(a)};
            #1;
            checks++;
            if (rd_m !== 16'h0000) begin errors++; $display("FAIL reset_read addr=%0d actual=%h required=0000", a, rd_m); end
        end
    endtask

    task automatic test_masked_write();
        r_addr = {4'd3, 4'd3};
        do_write(4'd3, 8'hA5, 8'hFF);
        wr_en = 1'b1; w_addr = 4'd3; w_data = 8'h0F; w_mask = 8'h0F;
        #1;
        checks++;
        if (rd_m[15:8] !== 8'hAF) begin errors++; $display("FAIL masked_bypass actual=%h required=AF", rd_m[15:8]); end
        checks++;
        if (rd_nb[15:8] !== 8'hA5) begin errors++; $display("FAIL masked_nobypass_old actual=%h required=A5", rd_nb[15:8]); end
        step();
        wr_en = 1'b0;
        checks++;
        if (rd_m[7:0] !== 8'hAF) begin errors++; $display("FAIL masked_result actual=%h required=AF", rd_m[7:0]); end
        // Zero mask: no change, no drop.
        wr_en = 1'b1; w_addr = 4'd3; w_data = 8'h00; w_mask = 8'h00;
        #1;
        checks++;
        if (drop_m !== 1'b0) begin errors++; $display("FAIL zero_mask_drop actual=%b required=0", drop_m); end
        step();
        wr_en = 1'b0;
        checks++;
        if (rd_m[7:0] !== 8'hAF) begin errors++; $display("FAIL zero_mask_keep actual=%h required=AF", rd_m[7:0]); end
    endtask

    task automatic test_bypass();
        r_addr = {4'd0, 4'd7};
        wr_en = 1'b1; w_addr = 4'd7; w_data = 8'h3C; w_mask = 8'hFF;
        #1;
        checks++;
        if (rd_m[7:0] !== 8'h3C) begin errors++; $display("FAIL bypass_same_cycle actual=%h required=3C", rd_m[7:0]); end
        checks++;
        if (rd_nb[7:0] !== 8'h00) begin errors++; $display("FAIL nobypass_old actual=%h required=00", rd_nb[7:0]); end
        step();
        wr_en = 1'b0;
        checks++;
        if (rd_nb[7:0] !== 8'h3C) begin errors++; $display("FAIL nobypass_next actual=%h required=3C", rd_nb[7:0]); end
        checks++;
        if (rd_rr[7:0] !== 8'h3C) begin errors++; $display("FAIL regread_bypass actual=%h required=3C", rd_rr[7:0]); end
    endtask

    task automatic test_reg_read();
        do_write(4'd2, 8'h22, 8'hFF);
        do_write(4'd5, 8'h55, 8'hFF);
        r_addr = {4'd2, 4'd0};
        step();
        checks++;
        if (rd_rr[15:8] !== 8'h22) begin errors++; $display("FAIL regread_addr2 actual=%h required=22", rd_rr[15:8]); end
        r_addr = {4'd5, 4'd0};
        #1;
        checks++;
        if (rd_rr[15:8] !== 8'h22) begin errors++; $display("FAIL regread_early actual=%h required=22", rd_rr[15:8]); end
        checks++;
        if (rd_m[15:8] !== 8'h55) begin errors++; $display("FAIL comb_addr5 actual=%h required=55", rd_m[15:8]); end
        step();
        checks++;
        if (rd_rr[15:8] !== 8'h55) begin errors++; $display("FAIL regread_latency actual=%h required=55", rd_rr[15:8]); end
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int done_at  = -1;
        int done_cnt = 0;
        int drop_cnt = 0;
        fill_ff();
        r_addr  = {4'd15, 4'd0};
        clr_req = 1'b1;
        #1;
        checks++;
        if (busy_m !== 1'b0) begin errors++; $display("FAIL clr_busy_before_edge actual=%b required=0", busy_m); end
        step();
        clr_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            wr_en   = (busy_cnt == 3);
            w_addr  = 4'd0; w_data = 8'hAA; w_mask = 8'hFF;
            clr_req = (busy_cnt == 5);
            #1;
            if (drop_m) drop_cnt++;
            if (wr_en) begin
                checks++;
                if (drop_m !== 1'b1) begin errors++; $display("FAIL wr_drop_busy actual=%b required=1", drop_m); end
            end
            if (busy_m === 1'b1) begin
                busy_cnt++;
                if (done_m === 1'b1) begin done_at = busy_cnt; done_cnt++; end
                if (busy_cnt == 8) begin
                    checks++;
                    if (rd_m !== 16'hFF00) begin errors++; $display("FAIL read_mid_clear actual=%h required=FF00", rd_m); end
                end
            end else begin
                if (done_m === 1'b1) done_cnt++;
                if (busy_cnt > 0) break;
            end
            step();
        end
        wr_en   = 1'b0;
        clr_req = 1'b0;
        checks++;
        if (busy_cnt != 16) begin errors++; $display("FAIL clr_busy_cycles actual=%0d required=16", busy_cnt); end
        checks++;
        if (done_at != 16 || done_cnt != 1) begin
            errors++; $display("FAIL clr_done_pulse actual=cycle%0d/count%0d required=cycle16/count1", done_at, done_cnt);
        end
        checks++;
        if (drop_cnt != 1) begin errors++; $display("FAIL wr_drop_count actual=%0d required=1", drop_cnt); end
        for (int a = 0; a < 16; a += 2) begin
            r_addr = {4'(a + 1), 4'(a)};
            #1;
            checks++;
            if (rd_m !== 16'h0000) begin errors++; $display("FAIL after_clear addr=%0d actual=%h required=0000", a, rd_m); end
        end
    endtask

    task automatic test_reset_mid_clear();
        int done_seen = 0;
        fill_ff();
        r_addr  = {4'd10, 4'd15};
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (6) step();
        checks++;
        if (busy_m !== 1'b1 || rd_m !== 16'hFFFF) begin
            errors++; $display("FAIL pre_reset_state actual=busy%b/%h required=busy1/FFFF", busy_m, rd_m);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rd_m !== 16'h0000) begin errors++; $display("FAIL reset_mid_clear_data actual=%h required=0000", rd_m); end
        checks++;
        if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_mid_clear_busy actual=%b required=0", busy_m); end
        for (int c = 0; c < 30; c++) begin
            if (c == 3) reset = 1'b0;
            if (done_m === 1'b1) done_seen++;
            #5;
        end
        checks++;
        if (done_seen != 0 || busy_m !== 1'b0) begin
            errors++; $display("FAIL reset_abort actual=done%0d/busy%b required=done0/busy0", done_seen, busy_m);
        end
        for (int a = 0; a < 16; a += 2) begin
            r_addr = {4'(a + 1), 4'(a)};
            #1;
            checks++;
            if (rd_m !== 16'h0000) begin errors++; $display("FAIL after_reset addr=%0d actual=%h required=0000", a, rd_m); end
        end
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_bypass();
        test_reg_read();
        test_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
